// File: rtl/shift_pkg.sv
// Shared shift-op encodings and sequencer state type for shifter, sequencer and controller decode.
// Latency: n/a (type/constant definitions only).
// Backpressure: n/a.
package shift_pkg;

  // Shift op field width and encodings as decoded by the controller.
  localparam int SH_OP_W = 2;

  typedef logic [SH_OP_W-1:0] sh_op_t;

  localparam sh_op_t SH_PASS = 2'b00;  // no shift
  localparam sh_op_t SH_LSL  = 2'b01;  // logical left, zero fill
  localparam sh_op_t SH_LSR  = 2'b10;  // logical right, zero fill
  localparam sh_op_t SH_ASR  = 2'b11;  // arithmetic right, sign fill

  // Sequencer control states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } shseq_state_t;

  // True when an op needs no stepping at all (pass-through or zero count).
  function automatic logic sh_is_trivial(input sh_op_t op, input logic amt_zero);
    return (op == SH_PASS) || amt_zero;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit-position shift of a W-bit word for the 2-bit shift op.
// Latency: zero cycles (pure combinational).
// Backpressure: none; result follows inputs. Carry output present only with SHIFT_SEQ_FLAGS_EN.
import shift_pkg::*;

module shift_step #(
  parameter int W = 16
) (
  input  sh_op_t       op,
  input  logic [W-1:0] a,
`ifdef SHIFT_SEQ_FLAGS_EN
  output logic         carry,
`endif
  output logic [W-1:0] result
);

  // Single step: the vacated bit is zero for logical shifts and the sign for ASR.
  always_comb begin
    result = a;
    case (op)
      SH_LSL:  result = {a[W-2:0], 1'b0};
      SH_LSR:  result = {1'b0, a[W-1:1]};
      SH_ASR:  result = {a[W-1], a[W-1:1]};
      default: result = a;
    endcase
  end

`ifdef SHIFT_SEQ_FLAGS_EN
  // Bit that falls off the end on this step; pass shifts nothing out.
  always_comb begin
    carry = 1'b0;
    case (op)
      SH_LSL:  carry = a[W-1];
      SH_LSR:  carry = a[0];
      SH_ASR:  carry = a[0];
      default: carry = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: applies pass/LSL/LSR/ASR amt times, one bit position per clock.
// Latency: done in the cycle after edge N+k (k=amt, 0 for pass); one mandatory DONE cycle.
// Backpressure: start only accepted in IDLE; start while busy is dropped, not queued.
// Optional flag outputs c_out/z_out/n_out are built when SHIFT_SEQ_FLAGS_EN is defined.
import shift_pkg::*;

module shift_seq #(
  parameter int W     = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     in,
  input  logic [1:0]       shift,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
`ifdef SHIFT_SEQ_FLAGS_EN
  output logic             c_out,
  output logic             z_out,
  output logic             n_out,
`endif
  output logic [W-1:0]     sout
);

  shseq_state_t     state_q, state_d;
  logic [W-1:0]     acc_q;
  sh_op_t           op_q;
  logic [AMT_W-1:0] cnt_q;
  logic [W-1:0]     step_res;
  logic             accept;

  // A request is only taken when the unit is idle; anything else is ignored.
  assign accept = (state_q == S_IDLE) && start;

`ifdef SHIFT_SEQ_FLAGS_EN
  logic step_carry;
  logic carry_q;

  shift_step #(.W(W)) u_step (
    .op     (op_q),
    .a      (acc_q),
    .carry  (step_carry),
    .result (step_res)
  );
`else
  shift_step #(.W(W)) u_step (
    .op     (op_q),
    .a      (acc_q),
    .result (step_res)
  );
`endif

  // State register; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: trivial ops skip straight to DONE, otherwise count steps down.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = sh_is_trivial(sh_op_t'(shift), amt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then one step per cycle while shifting.
  // Outside SHIFT the accumulator holds, so the result stays visible until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      op_q  <= SH_PASS;
      cnt_q <= '0;
    end else if (accept) begin
      acc_q <= in;
      op_q  <= sh_op_t'(shift);
      cnt_q <= amt;
    end else if (state_q == S_SHIFT) begin
      acc_q <= step_res;
      cnt_q <= cnt_q - AMT_W'(1);
    end
  end

`ifdef SHIFT_SEQ_FLAGS_EN
  // Carry tracks the last bit shifted out; cleared on accept so zero-step ops report 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else if (accept) begin
      carry_q <= 1'b0;
    end else if (state_q == S_SHIFT) begin
      carry_q <= step_carry;
    end
  end

  assign c_out = carry_q;
  assign z_out = (acc_q == '0);
  assign n_out = acc_q[W-1];
`endif

  // Moore outputs straight from state and accumulator.
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sout = acc_q;

endmodule
